// File: rtl/pads_table_arbiter.sv
// ---------------------------------------------------------------------------
// pads_table_arbiter
//
// Shares one DEPTH-entry table between NREQ requesters. Each cycle at most
// one request is granted. The granted access is performed on that clock
// edge, and its response is presented on the next cycle.
//
// Handshakes (valid/ready):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   - Request side: the requester holds req_valid[r] and its fields stable
//     until req_ready[r] is seen. It may also drop req_valid[r] before that.
//     req_ready is combinational, has at most one bit set, and is 0 while
//     rst_n is 0.
//   - Response side: the rsp_* outputs stay stable while rsp_valid=1 and
//     rsp_ready=0. If a response is accepted, a new grant can be made on the
//     same edge.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/req_ready per-requester request handshake
//   req_write           1=write, 0=read
//   req_idx             requester r index at [r*IW +: IW]
//   req_wdata           requester r write data at [r*DW +: DW]
//   rsp_valid/rsp_ready response handshake
//   rsp_id              requester that owns the response
//   rsp_rdata           entry value before the access (0 on error)
//   rsp_err             index >= DEPTH; the access was suppressed
//
// Configuration macro:
//   PADS_ARB_FIXED_PRIO_EN  fixed priority: the lowest requester index wins.
//                           When it is undefined, arbitration is round-robin.
// ---------------------------------------------------------------------------
module pads_table_arbiter #(
  parameter int NREQ  = 2,
  parameter int DEPTH = 8,
  parameter int DW    = 32,
  localparam int IW   = $clog2(DEPTH),
  localparam int RW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*IW-1:0] req_idx,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [RW-1:0]      rsp_id,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err
);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  localparam logic [IW:0] DEPTH_L = (IW+1)'(DEPTH);

  state_t          state_q, state_d;
  logic [DW-1:0]   table_q [DEPTH];
  logic [DW-1:0]   table_d [DEPTH];
  logic [RW-1:0]   rsp_id_q, rsp_id_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
`ifndef PADS_ARB_FIXED_PRIO_EN
  localparam logic [RW-1:0] LAST_ID = RW'(NREQ-1);
  logic [RW-1:0]   ptr_q, ptr_d;
`endif

  logic            gnt_found;
  logic [RW-1:0]   gnt_id;
  logic            can_accept;
  logic            grant;
  logic            sel_write;
  logic [IW-1:0]   sel_idx;
  logic [DW-1:0]   sel_wdata;
  logic            idx_ok;
  logic [DW-1:0]   rd_val;

  // Arbitration: choose the winning requester from req_valid only.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
`ifdef PADS_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found && req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_id    = RW'(i);
      end
    end
`else
    // Cyclic search starting after ptr_q. The first pass covers ids above
    // the pointer. The second pass wraps around to ids 0..ptr_q.
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found && req_valid[i] && (RW'(i) > ptr_q)) begin
        gnt_found = 1'b1;
        gnt_id    = RW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found && req_valid[i] && (RW'(i) <= ptr_q)) begin
        gnt_found = 1'b1;
        gnt_id    = RW'(i);
      end
    end
`endif
  end

  // A new grant is allowed when no response is held, or when the held
  // response is accepted on this same edge.
  assign can_accept = (state_q == S_IDLE) || rsp_ready;
  assign grant      = rst_n && can_accept && gnt_found;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_id] = 1'b1;
  end

  // Mux the winning requester's fields.
  always_comb begin
    sel_write = 1'b0;
    sel_idx   = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (RW'(i) == gnt_id) begin
        sel_write = req_write[i];
        sel_idx   = req_idx[i*IW +: IW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  assign idx_ok = ({1'b0, sel_idx} < DEPTH_L);
  assign rd_val = idx_ok ? table_q[sel_idx] : '0;

  // Next-state and table update.
  always_comb begin
    state_d     = state_q;
    rsp_id_d    = rsp_id_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    table_d     = table_q;
`ifndef PADS_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    if (grant) begin
      state_d     = S_RESP;
      rsp_id_d    = gnt_id;
      rsp_rdata_d = rd_val;
      rsp_err_d   = !idx_ok;
`ifndef PADS_ARB_FIXED_PRIO_EN
      ptr_d       = gnt_id;
`endif
      if (sel_write && idx_ok) table_d[sel_idx] = sel_wdata;
    end else if ((state_q == S_RESP) && rsp_ready) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rsp_id_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifndef PADS_ARB_FIXED_PRIO_EN
      ptr_q       <= LAST_ID;
`endif
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifndef PADS_ARB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
      table_q     <= table_d;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_pads_table_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for pads_table_arbiter (NREQ=3, DEPTH=6, DW=16).
// Stages: directed vector table, randomized traffic against a reference
// model, and a hand sequence for reset while a response is pending.
// ---------------------------------------------------------------------------
module tb_pads_table_arbiter;
  localparam int NREQ  = 3;
  localparam int DEPTH = 6;
  localparam int DW    = 16;
  localparam int IW    = 3;
  localparam int RW    = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid, req_ready, req_write;
  logic [NREQ*IW-1:0] req_idx;
  logic [NREQ*DW-1:0] req_wdata;
  logic               rsp_valid, rsp_ready, rsp_err;
  logic [RW-1:0]      rsp_id;
  logic [DW-1:0]      rsp_rdata;

  pads_table_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_idx(req_idx), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  // clock
  always #5 clk = ~clk;

  // per-requester stimulus arrays packed onto the DUT buses
  logic          v  [NREQ];
  logic          w  [NREQ];
  logic [IW-1:0] ix [NREQ];
  logic [DW-1:0] wd [NREQ];

  always_comb begin
    req_valid = '0;
    req_write = '0;
    req_idx   = '0;
    req_wdata = '0;
    for (int r = 0; r < NREQ; r++) begin
      req_valid[r]           = v[r];
      req_write[r]           = w[r];
      req_idx[r*IW +: IW]    = ix[r];
      req_wdata[r*DW +: DW]  = wd[r];
    end
  end

  // reference model: the table contents, the last granted id, and the
  // response currently held
  logic [DW-1:0] m_table [DEPTH];
  int            m_last;
  bit            m_v;
  int            m_id;
  logic [DW-1:0] m_rd;
  bit            m_err;
  int            m_g;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_table[i] = '0;
    m_last = NREQ - 1;
    m_v    = 1'b0;
    m_id   = 0;
    m_rd   = '0;
    m_err  = 1'b0;
  endtask

  // Returns the requester to be granted this cycle, or -1 if there is none.
  function automatic int m_pick();
    if (!rst_n) return -1;
    if (m_v && !rsp_ready) return -1;
`ifdef PADS_ARB_FIXED_PRIO_EN
    for (int r = 0; r < NREQ; r++) if (v[r]) return r;
`else
    for (int k = 1; k <= NREQ; k++) if (v[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
`endif
    return -1;
  endfunction

  // Sample after the inputs settle and compare against the model.
  task automatic settle(input string tag);
    logic [NREQ-1:0] exp_rdy;
    #1;
    m_g     = m_pick();
    exp_rdy = '0;
    if (m_g >= 0) exp_rdy[m_g] = 1'b1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(exp_rdy));
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(m_v));
    if (m_v) begin
      chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(m_id));
      chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'(m_rd));
      chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(m_err));
    end
  endtask

  // Clock edge, model update, then return at the next negedge.
  task automatic advance();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (m_g >= 0) begin
      m_id  = m_g;
      m_err = (int'(ix[m_g]) >= DEPTH);
      if (!m_err) begin
        m_rd = m_table[ix[m_g]];
        if (w[m_g]) m_table[ix[m_g]] = wd[m_g];
      end else begin
        m_rd = '0;
      end
      m_v    = 1'b1;
      m_last = m_g;
    end else if (m_v && rsp_ready) begin
      m_v = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic set_idle();
    for (int r = 0; r < NREQ; r++) begin
      v[r] = 1'b0; w[r] = 1'b0; ix[r] = '0; wd[r] = '0;
    end
  endtask

  // directed vectors: inputs for r0/r1 (r2 idle) plus expected outputs
  typedef struct packed {
    logic        rst;
    logic [2:0]  vld;
    logic [2:0]  wr;
    logic [2:0]  i0;
    logic [2:0]  i1;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        rr;
    logic [2:0]  e_rdy;
    logic        e_v;
    logic [1:0]  e_id;
    logic [15:0] e_rd;
    logic        e_err;
    logic        chk_data;
  } vec_t;

  function automatic vec_t mk(int rst, int vld, int wr, int i0, int i1, int d0, int d1,
                              int rr, int e_rdy, int e_v, int e_id, int e_rd, int e_err,
                              int chk_data);
    vec_t m;
    m.rst = 1'(rst); m.vld = 3'(vld); m.wr = 3'(wr); m.i0 = 3'(i0); m.i1 = 3'(i1);
    m.d0 = 16'(d0); m.d1 = 16'(d1); m.rr = 1'(rr); m.e_rdy = 3'(e_rdy); m.e_v = 1'(e_v);
    m.e_id = 2'(e_id); m.e_rd = 16'(e_rd); m.e_err = 1'(e_err); m.chk_data = 1'(chk_data);
    return m;
  endfunction

  vec_t vecs [20];

  initial begin
    //              rst vld    wr     i0 i1 d0  d1  rr  rdy   v  id rd  err chk
    vecs[0]  = mk(0, 3'b000, 3'b000, 0, 0, 0,  0,  1, 3'b000, 0, 0, 0,  0, 1);
    // write idx3=33, then read it back
    vecs[1]  = mk(1, 3'b001, 3'b001, 3, 0, 33, 0,  1, 3'b001, 0, 0, 0,  0, 1);
    vecs[2]  = mk(1, 3'b001, 3'b000, 3, 0, 0,  0,  1, 3'b001, 1, 0, 0,  0, 1);
    vecs[3]  = mk(1, 3'b000, 3'b000, 0, 0, 0,  0,  1, 3'b000, 1, 0, 33, 0, 1);
    // reset, then r0 and r1 both write idx3
    vecs[4]  = mk(0, 3'b000, 3'b000, 0, 0, 0,  0,  1, 3'b000, 0, 0, 0,  0, 0);
    vecs[5]  = mk(1, 3'b011, 3'b011, 3, 3, 11, 22, 1, 3'b001, 0, 0, 0,  0, 1);
    vecs[6]  = mk(1, 3'b010, 3'b011, 3, 3, 11, 22, 1, 3'b010, 1, 0, 0,  0, 1);
    vecs[7]  = mk(1, 3'b001, 3'b000, 3, 0, 0,  0,  1, 3'b001, 1, 1, 11, 0, 1);
    vecs[8]  = mk(1, 3'b000, 3'b000, 0, 0, 0,  0,  1, 3'b000, 1, 0, 22, 0, 1);
    // continuous reads from r0 and r1 alternate
    vecs[9]  = mk(1, 3'b011, 3'b000, 1, 2, 0,  0,  1, 3'b010, 0, 0, 0,  0, 0);
    vecs[10] = mk(1, 3'b011, 3'b000, 1, 2, 0,  0,  1, 3'b001, 1, 1, 0,  0, 1);
    vecs[11] = mk(1, 3'b011, 3'b000, 1, 2, 0,  0,  1, 3'b010, 1, 0, 0,  0, 1);
    // stall on rsp_ready=0 with r1 pending
    vecs[12] = mk(1, 3'b010, 3'b000, 0, 3, 0,  0,  0, 3'b000, 1, 1, 0,  0, 1);
    vecs[13] = mk(1, 3'b010, 3'b000, 0, 3, 0,  0,  0, 3'b000, 1, 1, 0,  0, 1);
    vecs[14] = mk(1, 3'b010, 3'b000, 0, 3, 0,  0,  0, 3'b000, 1, 1, 0,  0, 1);
    vecs[15] = mk(1, 3'b010, 3'b000, 0, 3, 0,  0,  1, 3'b010, 1, 1, 0,  0, 1);
    vecs[16] = mk(1, 3'b000, 3'b000, 0, 0, 0,  0,  1, 3'b000, 1, 1, 22, 0, 1);
    // out-of-range indices
    vecs[17] = mk(1, 3'b001, 3'b001, 7, 0, 5,  0,  1, 3'b001, 0, 0, 0,  0, 0);
    vecs[18] = mk(1, 3'b001, 3'b001, 6, 0, 5,  0,  1, 3'b001, 1, 0, 0,  1, 1);
    vecs[19] = mk(1, 3'b000, 3'b000, 0, 0, 0,  0,  1, 3'b000, 1, 0, 0,  1, 1);

    // reset block
    set_idle();
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    // table-driven vectors
    for (int k = 0; k < 20; k++) begin
      rst_n     = vecs[k].rst;
      for (int r = 0; r < NREQ; r++) begin
        v[r] = vecs[k].vld[r];
        w[r] = vecs[k].wr[r];
      end
      ix[0] = vecs[k].i0; ix[1] = vecs[k].i1; ix[2] = '0;
      wd[0] = vecs[k].d0; wd[1] = vecs[k].d1; wd[2] = '0;
      rsp_ready = vecs[k].rr;
      settle($sformatf("vec%0d", k));
`ifndef PADS_ARB_FIXED_PRIO_EN
      chk($sformatf("vec%0d_exp_ready", k), 32'(req_ready), 32'(vecs[k].e_rdy));
      chk($sformatf("vec%0d_exp_valid", k), 32'(rsp_valid), 32'(vecs[k].e_v));
      if (vecs[k].chk_data) begin
        chk($sformatf("vec%0d_exp_id", k), 32'(rsp_id), 32'(vecs[k].e_id));
        chk($sformatf("vec%0d_exp_rdata", k), 32'(rsp_rdata), 32'(vecs[k].e_rd));
        chk($sformatf("vec%0d_exp_err", k), 32'(rsp_err), 32'(vecs[k].e_err));
      end
`endif
      advance();
    end

    // randomized traffic against the model
    set_idle();
    for (int c = 0; c < 600; c++) begin
      int prev_g;
      prev_g    = m_g;
      rst_n     = ($urandom_range(0, 99) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < NREQ; r++) begin
        if (!v[r] || (prev_g == r) || ($urandom_range(0, 15) == 0)) begin
          v[r]  = 1'($urandom_range(0, 1));
          w[r]  = 1'($urandom_range(0, 1));
          ix[r] = IW'($urandom_range(0, 7));
          wd[r] = DW'($urandom);
        end
      end
      settle("rnd");
      advance();
    end

    // reset with a response pending
    set_idle();
    rsp_ready = 1'b1;
    rst_n = 1'b0; settle("t6_rst"); advance();
    rst_n = 1'b1;
    v[0] = 1'b1; w[0] = 1'b1; ix[0] = 3'd2; wd[0] = 16'd9;
    settle("t6_wr"); advance();
    set_idle();
    rst_n = 1'b0; rsp_ready = 1'b0;
    settle("t6_pend");
    chk("t6_pending_valid", 32'(rsp_valid), 32'd1);
    advance();
    rst_n = 1'b1; rsp_ready = 1'b1;
    settle("t6_after");
    chk("t6_dropped_valid", 32'(rsp_valid), 32'd0);
    advance();
    for (int k = 0; k <= DEPTH; k++) begin
      v[0]  = (k < DEPTH);
      w[0]  = 1'b0;
      ix[0] = IW'(k % DEPTH);
      settle($sformatf("t6_rd%0d", k));
      if (k > 0) begin
        chk($sformatf("t6_read_valid%0d", k - 1), 32'(rsp_valid), 32'd1);
        chk($sformatf("t6_read_zero%0d", k - 1), 32'(rsp_rdata), 32'd0);
      end
      advance();
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
